// File: rtl/i2s_pkg.sv
// i2s_pkg: shared state encoding and LR slot constants for the I2S receive path.
//   Exports state_t (HUNT, SHIFT_L, PAD_L, SHIFT_R, PAD_R), LR_LEFT, LR_RIGHT.
package i2s_pkg;

    typedef enum logic [2:0] {
        HUNT,
        SHIFT_L,
        PAD_L,
        SHIFT_R,
        PAD_R
    } state_t;

    localparam logic LR_LEFT  = 1'b0;
    localparam logic LR_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_sync_edge.sv
// i2s_sync_edge: 2-flop synchronizer with a rising-edge strobe from flops 2 and 3.
//   clk   in  : system clock
//   reset in  : synchronous, active-low
//   din   in  : asynchronous input
//   rise  out : one-cycle strobe per synchronized rising edge of din
module i2s_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic [2:0] sr;

    always_ff @(posedge clk) begin
        if (!reset) sr <= '0;
        else        sr <= {sr[1:0], din};
    end

    assign rise = sr[1] & ~sr[2];

endmodule

// File: rtl/i2s_rx_capture.sv
// i2s_rx_capture: deserialises the codec I2S ADC stream into left/right sample pairs.
//   clk, reset (sync active-low)      : system clock domain
//   i2s_bclk, i2s_lr, i2s_sdata       : asynchronous codec pins
//   left_sample, right_sample         : last complete stereo pair
//   sample_valid                      : one-cycle pulse when the pair updates
//   frame_error                       : one-cycle pulse when a slot ends short
//   locked                            : a full valid frame has been seen
module i2s_rx_capture
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i2s_bclk,
    input  logic                  i2s_lr,
    input  logic                  i2s_sdata,
    output logic [DATA_WIDTH-1:0] left_sample,
    output logic [DATA_WIDTH-1:0] right_sample,
    output logic                  sample_valid,
    output logic                  frame_error,
    output logic                  locked
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    logic                  bit_stb;
    logic [1:0]            lr_ff, sd_ff;
    logic                  lr_s, sd_s, lr_prev, slot_start;
    state_t                state, state_n;
    logic [CW-1:0]         bit_cnt, cnt_n;
    logic [DATA_WIDTH-1:0] left_shadow, lsh_n, right_shift, rsh_n, left_n, right_n;
    logic                  valid_n, err_n, locked_n;

    i2s_sync_edge u_bclk (
        .clk   (clk),
        .reset (reset),
        .din   (i2s_bclk),
        .rise  (bit_stb)
    );

    // lr and sdata share the bclk synchronizer depth so they line up with bit_stb
    always_ff @(posedge clk) begin
        if (!reset) begin
            lr_ff <= '0;
            sd_ff <= '0;
        end else begin
            lr_ff <= {lr_ff[0], i2s_lr};
            sd_ff <= {sd_ff[0], i2s_sdata};
        end
    end

    assign lr_s       = lr_ff[1];
    assign sd_s       = sd_ff[1];
    assign slot_start = lr_s != lr_prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= HUNT;
            lr_prev      <= 1'b0;
            bit_cnt      <= '0;
            left_shadow  <= '0;
            right_shift  <= '0;
            left_sample  <= '0;
            right_sample <= '0;
            sample_valid <= 1'b0;
            frame_error  <= 1'b0;
            locked       <= 1'b0;
        end else begin
            state        <= state_n;
            lr_prev      <= bit_stb ? lr_s : lr_prev;
            bit_cnt      <= cnt_n;
            left_shadow  <= lsh_n;
            right_shift  <= rsh_n;
            left_sample  <= left_n;
            right_sample <= right_n;
            sample_valid <= valid_n;
            frame_error  <= err_n;
            locked       <= locked_n;
        end
    end

    // The strobe that reveals an lr change carries the previous slot's trailing
    // bit, so a slot start never shifts data; the MSB arrives on the next strobe.
    always_comb begin
        state_n  = state;
        cnt_n    = bit_cnt;
        lsh_n    = left_shadow;
        rsh_n    = right_shift;
        left_n   = left_sample;
        right_n  = right_sample;
        valid_n  = 1'b0;
        err_n    = 1'b0;
        locked_n = locked;
        if (bit_stb) begin
            case (state)
                HUNT: begin
                    if (slot_start && lr_s == LR_LEFT) begin
                        state_n = SHIFT_L;
                        cnt_n   = '0;
                    end
                end
                SHIFT_L, SHIFT_R: begin
                    if (slot_start) begin
                        // short slot: drop the partial word, resync if a left slot begins
                        err_n    = 1'b1;
                        locked_n = 1'b0;
                        cnt_n    = '0;
                        state_n  = (lr_s == LR_LEFT) ? SHIFT_L : HUNT;
                    end else if (state == SHIFT_L) begin
                        lsh_n = {left_shadow[DATA_WIDTH-2:0], sd_s};
                        if (bit_cnt == LAST) state_n = PAD_L;
                        else                 cnt_n   = bit_cnt + 1'b1;
                    end else begin
                        rsh_n = {right_shift[DATA_WIDTH-2:0], sd_s};
                        if (bit_cnt == LAST) begin
                            left_n   = left_shadow;
                            right_n  = {right_shift[DATA_WIDTH-2:0], sd_s};
                            valid_n  = 1'b1;
                            locked_n = 1'b1;
                            state_n  = PAD_R;
                        end else begin
                            cnt_n = bit_cnt + 1'b1;
                        end
                    end
                end
                PAD_L: begin
                    if (slot_start && lr_s == LR_RIGHT) begin
                        state_n = SHIFT_R;
                        cnt_n   = '0;
                    end
                end
                PAD_R: begin
                    if (slot_start) begin
                        cnt_n = '0;
                        if (lr_s == LR_LEFT) begin
                            state_n = SHIFT_L;
                        end else begin
                            err_n    = 1'b1;
                            locked_n = 1'b0;
                            state_n  = HUNT;
                        end
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_rx_capture.sv
// tb_i2s_rx_capture: directed bench for i2s_rx_capture driving codec-style I2S slots.
module tb_i2s_rx_capture;
    import i2s_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        bclk = 1'b0;
    logic        lr_pin = 1'b0;
    logic        sd_pin = 1'b0;
    logic [23:0] left_sample, right_sample;
    logic        sample_valid, frame_error, locked;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int nvalid = 0;
    int nerr = 0;
    logic [23:0] v_l [32];
    logic [23:0] v_r [32];
    int          v_t [32];

    i2s_rx_capture #(.DATA_WIDTH(24)) dut (
        .clk          (clk),
        .reset        (reset),
        .i2s_bclk     (bclk),
        .i2s_lr       (lr_pin),
        .i2s_sdata    (sd_pin),
        .left_sample  (left_sample),
        .right_sample (right_sample),
        .sample_valid (sample_valid),
        .frame_error  (frame_error),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (sample_valid && nvalid < 32) begin
            v_l[nvalid] = left_sample;
            v_r[nvalid] = right_sample;
            v_t[nvalid] = cyc;
        end
        if (sample_valid) nvalid++;
        if (frame_error) nerr++;
        if (sample_valid || frame_error) begin
            n_checks++;
            assert (!(sample_valid && frame_error))
            else begin
                n_fail++;
                $error("FAIL valid_err_overlap: got both high, expected exclusive");
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // one bclk period of 32 clk: data changes while bclk is low, sampled on its rise
    task automatic bit_cyc(input logic lr, input logic d);
        @(negedge clk);
        bclk = 1'b0;
        lr_pin = lr;
        sd_pin = d;
        repeat (16) @(negedge clk);
        bclk = 1'b1;
        repeat (15) @(negedge clk);
    endtask

    // bit k of a slot: k=0 is the previous slot's trailing bit, 1..24 are MSB..LSB
    task automatic slot(input logic lr, input logic [23:0] w, input int k0, input int k1);
        for (int k = k0; k < k1; k++)
            bit_cyc(lr, (k >= 1 && k <= 24) ? w[24-k] : 1'b0);
    endtask

    task automatic frame(input logic [23:0] l, input logic [23:0] r);
        slot(1'b0, l, 0, 32);
        slot(1'b1, r, 0, 32);
    endtask

    initial begin
        // 1: reset held with bclk running
        for (int i = 0; i < 7; i++) bit_cyc(1'(i & 1), 1'b1);
        check("rst_left", 32'(left_sample), 32'h0);
        check("rst_right", 32'(right_sample), 32'h0);
        check("rst_valid", 32'(sample_valid), 32'h0);
        check("rst_err", 32'(frame_error), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_pulses", 32'(nvalid), 32'h0);

        // 2: one clean frame after a leading right slot
        @(negedge clk);
        reset = 1'b1;
        slot(1'b1, 24'h0, 0, 32);
        check("t2_pre_locked", 32'(locked), 32'h0);
        frame(24'h123456, 24'hABCDEF);
        check("t2_pulses", 32'(nvalid), 32'd1);
        check("t2_left", 32'(v_l[0]), 32'h123456);
        check("t2_right", 32'(v_r[0]), 32'hABCDEF);
        check("t2_hold_left", 32'(left_sample), 32'h123456);
        check("t2_locked", 32'(locked), 32'h1);
        check("t2_errs", 32'(nerr), 32'h0);

        // 3: reset across a left slot, released mid right slot
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t3_rst_left", 32'(left_sample), 32'h0);
        check("t3_rst_locked", 32'(locked), 32'h0);
        slot(1'b0, 24'h777777, 0, 32);
        slot(1'b1, 24'h666666, 0, 10);
        reset = 1'b1;
        slot(1'b1, 24'h666666, 10, 32);
        check("t3_partial_pulses", 32'(nvalid), 32'd1);
        frame(24'h5A5A5A, 24'h3C3C3C);
        check("t3_pulses", 32'(nvalid), 32'd2);
        check("t3_left", 32'(v_l[1]), 32'h5A5A5A);
        check("t3_right", 32'(v_r[1]), 32'h3C3C3C);
        check("t3_locked", 32'(locked), 32'h1);

        // 4: left slot cut after 10 data bits
        slot(1'b0, 24'hFFFFFF, 0, 11);
        slot(1'b1, 24'h0, 0, 32);
        check("t4_errs", 32'(nerr), 32'd1);
        check("t4_locked", 32'(locked), 32'h0);
        check("t4_pulses", 32'(nvalid), 32'd2);
        check("t4_state", 32'(dut.state), 32'(HUNT));
        frame(24'h000001, 24'hFFFFFF);
        check("t4_good_pulses", 32'(nvalid), 32'd3);
        check("t4_left", 32'(v_l[2]), 32'h000001);
        check("t4_right", 32'(v_r[2]), 32'hFFFFFF);
        check("t4_relocked", 32'(locked), 32'h1);

        // 5: back-to-back frames
        frame(24'h800000, 24'h7FFFFF);
        frame(24'h000000, 24'hFFFFFF);
        check("t5_pulses", 32'(nvalid), 32'd5);
        check("t5_left_a", 32'(v_l[3]), 32'h800000);
        check("t5_right_a", 32'(v_r[3]), 32'h7FFFFF);
        check("t5_left_b", 32'(v_l[4]), 32'h000000);
        check("t5_right_b", 32'(v_r[4]), 32'hFFFFFF);
        check("t5_spacing", 32'(v_t[4] - v_t[3]), 32'd2048);
        check("t5_errs", 32'(nerr), 32'd1);

        // 6: one-cycle reset mid left capture
        slot(1'b0, 24'h111111, 0, 13);
        check("t6_pre_state", 32'(dut.state), 32'(SHIFT_L));
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("t6_state", 32'(dut.state), 32'(HUNT));
        check("t6_left", 32'(left_sample), 32'h0);
        check("t6_right", 32'(right_sample), 32'h0);
        check("t6_locked", 32'(locked), 32'h0);
        check("t6_valid", 32'(sample_valid), 32'h0);
        slot(1'b0, 24'h111111, 13, 32);
        slot(1'b1, 24'h222222, 0, 32);
        check("t6_no_pulse", 32'(nvalid), 32'd5);
        frame(24'h0ABCDE, 24'h0FEDCB);
        check("t6_pulses", 32'(nvalid), 32'd6);
        check("t6_left_rec", 32'(v_l[5]), 32'h0ABCDE);
        check("t6_right_rec", 32'(v_r[5]), 32'h0FEDCB);
        check("t6_locked_rec", 32'(locked), 32'h1);
        check("t6_errs", 32'(nerr), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
